// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA types, colour and timing constants, bounce hit helper
package vga_pkg;

  typedef logic [15:0] rgb565_t;
  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;

  localparam int H_VALID = 640;
  localparam int V_VALID = 480;

  localparam rgb565_t BLACK = 16'h0000;
  localparam rgb565_t WHITE = 16'hFFFF;
  localparam rgb565_t RED   = 16'hF800;
  localparam rgb565_t GREEN = 16'h07E0;
  localparam rgb565_t BLUE  = 16'h001F;

  // True when the next step along dir would reach or pass an edge.
  function automatic logic axis_hit(input logic [9:0] pos, input dir_t dir,
                                    input logic [10:0] max_pos, input logic [10:0] step);
    logic [10:0] pos_w;
    pos_w = {1'b0, pos};
    if (dir == DIR_POS) return (pos_w + step) >= max_pos;
    return pos_w <= step;
  endfunction

endpackage

// File: rtl/vga_pic_bounce_if.sv
// rtl/vga_pic_bounce_if.sv - picture ROM read port
interface vga_pic_bounce_if #(parameter int ADDR_W = 14);
  import vga_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd_en;
  rgb565_t           rom_data;

  modport master (output rom_addr, rom_rd_en, input rom_data);
  modport slave  (input rom_addr, rom_rd_en, output rom_data);
endinterface

// File: rtl/bounce_axis.sv
// rtl/bounce_axis.sv - one axis of the bouncing image position
module bounce_axis
  import vga_pkg::*;
#(
  parameter int LIMIT = 640,
  parameter int SIZE  = 100,
  parameter int STEP  = 1
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       upd,
  output logic [9:0] pos,
  output dir_t       dir
);

  localparam logic [10:0] MAX_POS = 11'(LIMIT - SIZE);
  localparam logic [10:0] STEP_W  = 11'(STEP);

  logic       hit;
  logic [9:0] fwd, back;

  assign hit  = axis_hit(pos, dir, MAX_POS, STEP_W);
  // Only used when no edge is hit, so neither can leave the 0..MAX_POS range.
  assign fwd  = pos + 10'(STEP);
  assign back = pos - 10'(STEP);

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      pos <= '0;
      dir <= DIR_POS;
    end else if (upd) begin
      if (dir == DIR_POS) begin
        if (hit) begin
          pos <= 10'(MAX_POS);
          dir <= DIR_NEG;
        end else begin
          pos <= fwd;
        end
      end else begin
        if (hit) begin
          pos <= '0;
          dir <= DIR_POS;
        end else begin
          pos <= back;
        end
      end
    end
  end

endmodule

// File: rtl/vga_pic_bounce.sv
// rtl/vga_pic_bounce.sv - bouncing ROM picture generator for the VGA pixel chain
// Optional inverted flash on bounce: VGA_PIC_BOUNCE_FLASH_EN.
module vga_pic_bounce
  import vga_pkg::*;
#(
  parameter int      H_VALID   = vga_pkg::H_VALID,
  parameter int      V_VALID   = vga_pkg::V_VALID,
  parameter int      PIC_W     = 100,
  parameter int      PIC_H     = 100,
  parameter int      STEP_X    = 1,
  parameter int      STEP_Y    = 1,
  parameter int      FRAME_DIV = 1,
  parameter rgb565_t BG_COLOR  = BLACK,
  parameter int      ADDR_W    = $clog2(PIC_W * PIC_H)
) (
  input  logic                    vga_clk,
  input  logic                    sys_rst,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    move_en,
  vga_pic_bounce_if.master        rom,
  output rgb565_t                 pix_data,
  output logic [9:0]              x_pos,
  output logic [9:0]              y_pos
);

  localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [ADDR_W-1:0] PIC_W_A = ADDR_W'(PIC_W);

  generate
    if (PIC_W > H_VALID || PIC_H > V_VALID || FRAME_DIV < 1) begin : g_bad_cfg
      $error("vga_pic_bounce: picture larger than screen or FRAME_DIV < 1");
    end
  endgenerate

  logic [10:0]       px_w, py_w, xp_w, yp_w;
  logic              in_pic, frame_end, last_div, upd;
  logic [FC_W-1:0]   frame_cnt;
  logic [ADDR_W-1:0] addr_calc;
  dir_t              dir_x, dir_y;
  rgb565_t           pix_tint;

  assign px_w = {1'b0, pix_x};
  assign py_w = {1'b0, pix_y};
  assign xp_w = {1'b0, x_pos};
  assign yp_w = {1'b0, y_pos};

  assign in_pic = (px_w < 11'(H_VALID)) && (py_w < 11'(V_VALID)) &&
                  (px_w >= xp_w) && (px_w < xp_w + 11'(PIC_W)) &&
                  (py_w >= yp_w) && (py_w < yp_w + 11'(PIC_H));

  assign frame_end = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
  assign last_div  = (frame_cnt == FC_W'(FRAME_DIV - 1));
  assign upd       = frame_end && last_div && move_en;
  assign addr_calc = ADDR_W'(pix_y - y_pos) * PIC_W_A + ADDR_W'(pix_x - x_pos);

  bounce_axis #(.LIMIT(H_VALID), .SIZE(PIC_W), .STEP(STEP_X)) u_axis_x (
    .clk(vga_clk), .sys_rst(sys_rst), .upd(upd), .pos(x_pos), .dir(dir_x)
  );

  bounce_axis #(.LIMIT(V_VALID), .SIZE(PIC_H), .STEP(STEP_Y)) u_axis_y (
    .clk(vga_clk), .sys_rst(sys_rst), .upd(upd), .pos(y_pos), .dir(dir_y)
  );

  // rom_rd_en doubles as the delayed hit flag for the output mux.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      frame_cnt     <= '0;
      rom.rom_addr  <= '0;
      rom.rom_rd_en <= 1'b0;
    end else begin
      if (frame_end) frame_cnt <= last_div ? '0 : frame_cnt + 1'b1;
      rom.rom_rd_en <= in_pic;
      if (in_pic) rom.rom_addr <= addr_calc;
    end
  end

`ifdef VGA_PIC_BOUNCE_FLASH_EN
  rgb565_t tint;
  logic    flip;

  assign flip = upd && (axis_hit(x_pos, dir_x, 11'(H_VALID - PIC_W), 11'(STEP_X)) ||
                        axis_hit(y_pos, dir_y, 11'(V_VALID - PIC_H), 11'(STEP_Y)));

  // Tint is sampled with the request so a frame-boundary pixel keeps its own frame's tint.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      tint     <= BLACK;
      pix_tint <= BLACK;
    end else begin
      if (frame_end) tint <= flip ? WHITE : BLACK;
      pix_tint <= in_pic ? tint : BLACK;
    end
  end
`else
  logic dir_unused;
  assign dir_unused = dir_x ^ dir_y;
  assign pix_tint   = BLACK;
`endif

  always_comb begin
    pix_data = BG_COLOR;
    if (sys_rst)            pix_data = '0;
    else if (rom.rom_rd_en) pix_data = rom.rom_data ^ pix_tint;
  end

endmodule
